// File: rtl/rx_word_assembler.sv
// Byte-to-word front end: pops bytes from the UART RX FIFO, packs WORD_BYTES of them
// into one word in the chosen byte order and queues finished words behind a valid/ready port.
module rx_word_assembler #(
  parameter int BYTE_W      = 8,
  parameter int WORD_BYTES  = 2,
  parameter int BIG_ENDIAN  = 0,
  parameter int TIMEOUT_CYC = 1024,
  parameter int OUT_DEPTH   = 2,
  parameter int CNT_W       = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                flush,
  input  logic                                fifo_empty,
  output logic                                fifo_re,
  input  logic [BYTE_W-1:0]                   fifo_rd_data,
  output logic                                word_valid,
  input  logic                                word_ready,
  output logic [BYTE_W*WORD_BYTES-1:0]        word_data,
  output logic [$clog2(WORD_BYTES):0]         byte_idx,
  output logic                                err_timeout,
  output logic                                busy,
  output logic [CNT_W-1:0]                    word_cnt
);

  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int IDX_W  = $clog2(WORD_BYTES) + 1;
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int BCNT_W = $clog2(OUT_DEPTH + 1);
  localparam int TMO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  // Output handshake: a word transfers in every cycle where word_valid && word_ready are
  // both high at the rising edge; word_data is stable while word_valid is held and not taken.

  typedef enum logic {IDLE = 1'b0, CAP = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    lane;
  logic [WORD_W-1:0]   acc_q, acc_cap;
  logic [WORD_W-1:0]   buf_mem [OUT_DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [BCNT_W-1:0]   buf_count;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                rd_issue, capture, last_byte, push, pop, tmo_hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rd_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !fifo_empty && (buf_count < BCNT_W'(OUT_DEPTH)) && !flush) begin
          rd_issue = 1'b1;
          state_d  = CAP;
        end
      end
      CAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane 0 is the least significant byte of the word.
  always_comb begin
    lane    = (BIG_ENDIAN != 0) ? IDX_W'(WORD_BYTES - 1) - idx_q : idx_q;
    acc_cap = acc_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (lane == IDX_W'(i)) acc_cap[i*BYTE_W +: BYTE_W] = fifo_rd_data;
    end
  end

  assign last_byte = (idx_q == IDX_W'(WORD_BYTES - 1));
  assign capture   = (state_q == CAP) && !flush;
  assign push      = capture && last_byte;
  assign pop       = word_valid && word_ready && !flush;
  assign tmo_hit   = (TIMEOUT_CYC > 0) && (state_q == IDLE) && (idx_q != '0) && !rd_issue &&
                     !flush && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
      word_cnt    <= '0;
    end else begin
      err_timeout <= 1'b0;
      if (flush) begin
        idx_q   <= '0;
        acc_q   <= '0;
        tmo_cnt <= '0;
      end else if (capture) begin
        tmo_cnt <= '0;
        if (last_byte) begin
          idx_q    <= '0;
          acc_q    <= '0;
          word_cnt <= word_cnt + 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
          acc_q <= acc_cap;
        end
      end else if (tmo_hit) begin
        idx_q       <= '0;
        acc_q       <= '0;
        tmo_cnt     <= '0;
        err_timeout <= 1'b1;
      end else if (rd_issue || (idx_q == '0)) begin
        tmo_cnt <= '0;
      end else if ((state_q == IDLE) && (TIMEOUT_CYC > 0)) begin
        // Keeps counting with en low: a stalled partial word still ages out.
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      buf_count <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) buf_mem[i] <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      buf_count <= '0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= acc_cap;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   buf_count <= buf_count + 1'b1;
        2'b01:   buf_count <= buf_count - 1'b1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  assign fifo_re    = rd_issue && rst_n;
  assign word_valid = (buf_count != '0);
  assign word_data  = word_valid ? buf_mem[rd_ptr] : '0;
  assign byte_idx   = idx_q;
  assign busy       = (idx_q != '0) || (state_q == CAP);

endmodule

// File: tb/tb_rx_word_assembler.sv
// Directed bench for rx_word_assembler: a little-endian 16-bit instance with a short
// timeout and a big-endian 32-bit instance, each fed by a simple RX FIFO model.
module tb_rx_word_assembler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;

  // Little-endian 16-bit instance
  logic        fifo_empty, fifo_re, word_valid, word_ready, err_timeout, busy;
  logic [7:0]  fifo_rd_data;
  logic [15:0] word_data, word_cnt;
  logic [1:0]  byte_idx;

  // Big-endian 32-bit instance
  logic        b_empty, b_re, b_valid, b_ready, b_err, b_busy;
  logic [7:0]  b_rd_data;
  logic [31:0] b_data;
  logic [15:0] b_cnt;
  logic [2:0]  b_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rx_word_assembler #(.BYTE_W(8), .WORD_BYTES(2), .BIG_ENDIAN(0), .TIMEOUT_CYC(16),
                      .OUT_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_re(fifo_re), .fifo_rd_data(fifo_rd_data), .word_valid(word_valid),
    .word_ready(word_ready), .word_data(word_data), .byte_idx(byte_idx),
    .err_timeout(err_timeout), .busy(busy), .word_cnt(word_cnt));

  rx_word_assembler #(.BYTE_W(8), .WORD_BYTES(4), .BIG_ENDIAN(1), .TIMEOUT_CYC(0),
                      .OUT_DEPTH(2), .CNT_W(16)) dut_be (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .fifo_empty(b_empty),
    .fifo_re(b_re), .fifo_rd_data(b_rd_data), .word_valid(b_valid),
    .word_ready(b_ready), .word_data(b_data), .byte_idx(b_idx),
    .err_timeout(b_err), .busy(b_busy), .word_cnt(b_cnt));

  // RX FIFO models: data appears the cycle after the read strobe
  logic [7:0] fmem [128];
  logic [7:0] bmem [128];
  int fhead = 0, ftail = 0, bhead = 0, btail = 0;

  assign fifo_empty = (fhead == ftail);
  assign b_empty    = (bhead == btail);

  always @(posedge clk) begin
    if (fifo_re) begin
      fifo_rd_data <= fmem[fhead];
      fhead        <= fhead + 1;
    end
    if (b_re) begin
      b_rd_data <= bmem[bhead];
      bhead     <= bhead + 1;
    end
  end

  task automatic push_main(input logic [7:0] b);
    fmem[ftail] = b;
    ftail = ftail + 1;
  endtask

  task automatic push_be(input logic [7:0] b);
    bmem[btail] = b;
    btail = btail + 1;
  endtask

  // Per-cycle records, sampled mid-cycle
  logic        rec_re [32];
  logic        rec_val [32];
  logic        rec_err [32];
  logic        rec_busy [32];
  logic [2:0]  rec_idx [32];
  logic [15:0] rec_dat [32];
  logic        rec_bval [32];
  logic [2:0]  rec_bidx [32];
  logic [31:0] rec_bdat [32];

  task automatic capture_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rec_re[i]   = fifo_re;
      rec_val[i]  = word_valid;
      rec_err[i]  = err_timeout;
      rec_busy[i] = busy;
      rec_idx[i]  = {1'b0, byte_idx};
      rec_dat[i]  = word_data;
      rec_bval[i] = b_valid;
      rec_bidx[i] = b_idx;
      rec_bdat[i] = b_data;
    end
  endtask

  task automatic test_reset;
    word_ready = 1'b0;
    b_ready    = 1'b0;
    @(negedge clk);
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", word_valid); end
    n_checks++; if (word_data !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0000", word_data); end
    n_checks++; if (word_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", word_cnt); end
    n_checks++; if ({fifo_re, err_timeout, busy, byte_idx} !== 5'b0) begin n_fail++; $display("FAIL rst_flags: got re/err/busy/idx %b expected 00000", {fifo_re, err_timeout, busy, byte_idx}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    n_checks++; if ({word_valid, busy, b_valid, b_busy} !== 4'b0) begin n_fail++; $display("FAIL rst_release: got %b expected 0000", {word_valid, busy, b_valid, b_busy}); end
  endtask

  task automatic test_basic_le;
    int nre, nval;
    logic [15:0] d;
    @(posedge clk); #1;
    word_ready = 1'b1;
    push_main(8'hDE);
    push_main(8'hAD);
    capture_cycles(8);
    nre = 0; nval = 0; d = 16'h0;
    for (int i = 0; i < 8; i++) begin
      if (rec_re[i]) nre++;
      if (rec_val[i]) begin nval++; d = rec_dat[i]; end
    end
    n_checks++; if (nre !== 2) begin n_fail++; $display("FAIL le_re_pulses: got %0d expected 2", nre); end
    n_checks++; if (rec_idx[2] !== 3'd1) begin n_fail++; $display("FAIL le_idx_mid: got %0d expected 1", rec_idx[2]); end
    n_checks++; if (rec_busy[1] !== 1'b1) begin n_fail++; $display("FAIL le_busy_cap: got %b expected 1", rec_busy[1]); end
    n_checks++; if (rec_val[4] !== 1'b1) begin n_fail++; $display("FAIL le_valid_cycle: got %b expected 1", rec_val[4]); end
    n_checks++; if (nval !== 1) begin n_fail++; $display("FAIL le_valid_len: got %0d expected 1", nval); end
    n_checks++; if (d !== 16'hADDE) begin n_fail++; $display("FAIL le_word: got %h expected adde", d); end
    n_checks++; if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL le_cnt: got %0d expected 1", word_cnt); end
  endtask

  task automatic test_big_endian;
    int nval;
    @(posedge clk); #1;
    b_ready = 1'b1;
    push_be(8'h11); push_be(8'h22); push_be(8'h33); push_be(8'h44);
    capture_cycles(12);
    nval = 0;
    for (int i = 0; i < 12; i++) if (rec_bval[i]) nval++;
    n_checks++; if (rec_bidx[2] !== 3'd1) begin n_fail++; $display("FAIL be_idx1: got %0d expected 1", rec_bidx[2]); end
    n_checks++; if (rec_bidx[4] !== 3'd2) begin n_fail++; $display("FAIL be_idx2: got %0d expected 2", rec_bidx[4]); end
    n_checks++; if (rec_bidx[6] !== 3'd3) begin n_fail++; $display("FAIL be_idx3: got %0d expected 3", rec_bidx[6]); end
    n_checks++; if (rec_bidx[8] !== 3'd0) begin n_fail++; $display("FAIL be_idx0: got %0d expected 0", rec_bidx[8]); end
    n_checks++; if (rec_bval[8] !== 1'b1) begin n_fail++; $display("FAIL be_valid: got %b expected 1", rec_bval[8]); end
    n_checks++; if (rec_bdat[8] !== 32'h11223344) begin n_fail++; $display("FAIL be_word: got %h expected 11223344", rec_bdat[8]); end
    n_checks++; if (nval !== 1) begin n_fail++; $display("FAIL be_valid_len: got %0d expected 1", nval); end
    n_checks++; if (b_cnt !== 16'd1) begin n_fail++; $display("FAIL be_cnt: got %0d expected 1", b_cnt); end
  endtask

  task automatic test_back_to_back;
    int nre, npop;
    logic [15:0] got [4];
    @(posedge clk); #1;
    word_ready = 1'b0;
    push_main(8'h11); push_main(8'h22); push_main(8'h33);
    push_main(8'h44); push_main(8'h55); push_main(8'h66);
    capture_cycles(16);
    nre = 0;
    for (int i = 0; i < 16; i++) if (rec_re[i]) nre++;
    n_checks++; if (nre !== 4) begin n_fail++; $display("FAIL full_re_pulses: got %0d expected 4", nre); end
    n_checks++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL full_fifo_left: got %b expected 0", fifo_empty); end
    n_checks++; if (word_data !== 16'h2211) begin n_fail++; $display("FAIL full_head: got %h expected 2211", word_data); end
    @(posedge clk); #1;
    word_ready = 1'b1;
    capture_cycles(14);
    npop = 0;
    for (int i = 0; i < 14; i++) begin
      if (rec_val[i]) begin
        if (npop < 4) got[npop] = rec_dat[i];
        npop++;
      end
    end
    n_checks++; if (npop !== 3) begin n_fail++; $display("FAIL drain_count: got %0d expected 3", npop); end
    n_checks++; if (got[0] !== 16'h2211) begin n_fail++; $display("FAIL drain_w0: got %h expected 2211", got[0]); end
    n_checks++; if (got[1] !== 16'h4433) begin n_fail++; $display("FAIL drain_w1: got %h expected 4433", got[1]); end
    n_checks++; if (got[2] !== 16'h6655) begin n_fail++; $display("FAIL drain_w2: got %h expected 6655", got[2]); end
    n_checks++; if (word_cnt !== 16'd4) begin n_fail++; $display("FAIL drain_cnt: got %0d expected 4", word_cnt); end
  endtask

  task automatic test_timeout;
    int nerr, at, nval;
    logic [15:0] d;
    @(posedge clk); #1;
    word_ready = 1'b1;
    push_main(8'h5A);
    capture_cycles(24);
    nerr = 0; at = -1; nval = 0;
    for (int i = 0; i < 24; i++) begin
      if (rec_err[i]) begin nerr++; at = i; end
      if (rec_val[i]) nval++;
    end
    n_checks++; if (rec_idx[2] !== 3'd1) begin n_fail++; $display("FAIL tmo_partial: got %0d expected 1", rec_idx[2]); end
    n_checks++; if (nerr !== 1) begin n_fail++; $display("FAIL tmo_pulses: got %0d expected 1", nerr); end
    n_checks++; if (at !== 18) begin n_fail++; $display("FAIL tmo_cycle: got %0d expected 18", at); end
    n_checks++; if (rec_idx[18] !== 3'd0) begin n_fail++; $display("FAIL tmo_idx_clear: got %0d expected 0", rec_idx[18]); end
    n_checks++; if (nval !== 0) begin n_fail++; $display("FAIL tmo_no_word: got %0d expected 0", nval); end
    @(posedge clk); #1;
    push_main(8'h01);
    push_main(8'h02);
    capture_cycles(8);
    d = 16'hFFFF;
    for (int i = 7; i >= 0; i--) if (rec_val[i]) d = rec_dat[i];
    n_checks++; if (d !== 16'h0201) begin n_fail++; $display("FAIL tmo_next_word: got %h expected 0201", d); end
    n_checks++; if (word_cnt !== 16'd5) begin n_fail++; $display("FAIL tmo_cnt: got %0d expected 5", word_cnt); end
  endtask

  task automatic test_flush;
    int nval;
    logic [15:0] d;
    @(posedge clk); #1;
    word_ready = 1'b0;
    push_main(8'hAA); push_main(8'hBB); push_main(8'hCC); push_main(8'hDD);
    capture_cycles(7);
    n_checks++; if (rec_dat[6] !== 16'hBBAA) begin n_fail++; $display("FAIL fl_buffered: got %h expected bbaa", rec_dat[6]); end
    @(posedge clk); #1;
    flush = 1'b1;
    capture_cycles(1);
    n_checks++; if ({rec_busy[0], rec_re[0]} !== 2'b10) begin n_fail++; $display("FAIL fl_in_cap: got busy/re %b expected 10", {rec_busy[0], rec_re[0]}); end
    @(posedge clk); #1;
    flush = 1'b0;
    capture_cycles(1);
    n_checks++; if (rec_val[0] !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b expected 0", rec_val[0]); end
    n_checks++; if ({rec_idx[0], rec_busy[0]} !== 4'b0) begin n_fail++; $display("FAIL fl_idx_busy: got %b expected 0000", {rec_idx[0], rec_busy[0]}); end
    n_checks++; if (word_cnt !== 16'd6) begin n_fail++; $display("FAIL fl_cnt_kept: got %0d expected 6", word_cnt); end
    @(posedge clk); #1;
    word_ready = 1'b1;
    push_main(8'hBE);
    push_main(8'hEF);
    capture_cycles(8);
    nval = 0; d = 16'hFFFF;
    for (int i = 7; i >= 0; i--) if (rec_val[i]) begin nval++; d = rec_dat[i]; end
    n_checks++; if (d !== 16'hEFBE) begin n_fail++; $display("FAIL fl_next_word: got %h expected efbe", d); end
    n_checks++; if (nval !== 1) begin n_fail++; $display("FAIL fl_word_count: got %0d expected 1", nval); end
  endtask

  task automatic test_reset_mid_word;
    logic [15:0] d;
    logic [31:0] bd;
    @(posedge clk); #1;
    word_ready = 1'b0;
    b_ready    = 1'b0;
    push_main(8'h10); push_main(8'h20); push_main(8'h30); push_main(8'h40); push_main(8'h50);
    push_be(8'h71); push_be(8'h72);
    capture_cycles(10);
    n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL mr_buffered: got %b expected 1", word_valid); end
    n_checks++; if (b_idx !== 3'd2) begin n_fail++; $display("FAIL mr_be_partial: got %0d expected 2", b_idx); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({word_valid, busy, err_timeout, fifo_re, byte_idx} !== 6'b0) begin n_fail++; $display("FAIL mr_flags: got %b expected 000000", {word_valid, busy, err_timeout, fifo_re, byte_idx}); end
    n_checks++; if ({word_data, word_cnt} !== 32'h0) begin n_fail++; $display("FAIL mr_data_cnt: got %h expected 00000000", {word_data, word_cnt}); end
    n_checks++; if ({b_idx, b_busy, b_cnt} !== 20'h0) begin n_fail++; $display("FAIL mr_be_state: got %h expected 00000", {b_idx, b_busy, b_cnt}); end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n      = 1'b1;
    word_ready = 1'b1;
    b_ready    = 1'b1;
    push_main(8'h60);
    push_be(8'h73); push_be(8'h74); push_be(8'h75); push_be(8'h76);
    capture_cycles(12);
    d = 16'hFFFF; bd = 32'hFFFFFFFF;
    for (int i = 11; i >= 0; i--) begin
      if (rec_val[i]) d = rec_dat[i];
      if (rec_bval[i]) bd = rec_bdat[i];
    end
    n_checks++; if (d !== 16'h6050) begin n_fail++; $display("FAIL mr_le_after: got %h expected 6050", d); end
    n_checks++; if (bd !== 32'h73747576) begin n_fail++; $display("FAIL mr_be_after: got %h expected 73747576", bd); end
    n_checks++; if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL mr_cnt_after: got %0d expected 1", word_cnt); end
    n_checks++; if (b_cnt !== 16'd1) begin n_fail++; $display("FAIL mr_be_cnt_after: got %0d expected 1", b_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_le();
    test_big_endian();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_word_assembler.md
Name: rx_word_assembler

Overview:
Parametrised byte-to-word front end between the UART RX FIFO and the instruction controller. It pops bytes from the RX FIFO and packs WORD_BYTES consecutive bytes into one word, in configurable byte order. Completed words go through a small output buffer with a valid/ready handshake. An inter-byte timeout discards stalled partial words, and a flush input resynchronises the byte stream. It generalises the fixed 16-bit low-then-high instruction fetch to any word width and either byte order.

Parameters:
BYTE_W, 8, width of one FIFO byte.
WORD_BYTES, 2, bytes per assembled word (>=1).
BIG_ENDIAN, 0, 0: first byte lands in bits [BYTE_W-1:0]; 1: first byte lands in the MS lane.
TIMEOUT_CYC, 1024, idle cycles allowed with a partial word before discard; 0 disables the timeout.
OUT_DEPTH, 2, output word buffer entries (>=1).
CNT_W, 16, width of the completed-word counter.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
en  in  1  1: fetching allowed; 0: no new FIFO reads are issued.
flush  in  1  discards the partial word, any in-flight byte and the output buffer.
fifo_empty  in  1  RX FIFO empty.
fifo_re  out  1  RX FIFO read strobe, one-cycle pulse.
fifo_rd_data  in  BYTE_W  RX FIFO data, valid the cycle after fifo_re.
word_valid  out  1  output buffer non-empty.
word_ready  in  1  consumer accepts the head word.
word_data  out  BYTE_W*WORD_BYTES  head word of the output buffer.
byte_idx  out  clog2(WORD_BYTES)+1  bytes held in the current partial word.
err_timeout  out  1  one-cycle pulse when a partial word is discarded by timeout.
busy  out  1  partial word present, or a byte is in flight.
word_cnt  out  CNT_W  words written to the output buffer since reset; wraps.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE. fifo_re=0, word_valid=0, word_data=0, byte_idx=0, err_timeout=0, busy=0, word_cnt=0. Output buffer empty. Timeout counter=0. Reset mid-word discards all state.
- FSM states: IDLE and CAP.
- IDLE -> CAP when en && !fifo_empty && buf_count<OUT_DEPTH && !flush. In that cycle fifo_re=1 for exactly one cycle.
- CAP: samples fifo_rd_data into lane byte_idx (lane = byte_idx, or WORD_BYTES-1-byte_idx if BIG_ENDIAN), then byte_idx++.
  - If this was the last byte, the full word is written to the output buffer, byte_idx=0 and word_cnt++ in the same cycle.
  - CAP -> IDLE unconditionally.
- Throughput: at most one byte per 2 cycles. The word is visible on word_valid the cycle after the final CAP.
- Space check: a read is issued only when buf_count<OUT_DEPTH. At most one byte is in flight, so the output buffer never overflows.
- Output buffer: FIFO, first word out first. word_data always shows the head entry. Pop on word_valid && word_ready. Push and pop in the same cycle leave buf_count unchanged. When full, reads stall until a pop.
- Timeout (TIMEOUT_CYC>0): the counter increments each cycle in IDLE with byte_idx!=0 and no read issued. It clears on any fifo_re or when byte_idx=0.
  - When the count reaches TIMEOUT_CYC: byte_idx=0, lanes cleared, err_timeout=1 for one cycle, counter=0.
  - The count continues while en=0.
- flush (synchronous, highest priority): byte_idx=0, buffer emptied, word_valid=0 next cycle, timeout counter=0.
  - If flush arrives in CAP, the captured byte is dropped and the FSM goes to IDLE.
  - No fifo_re is issued during a flush cycle.
  - word_cnt is not cleared.
- en=0 mid-word: the partial word is retained and the fetch resumes when en=1.
- WORD_BYTES=1: every byte completes a word.
- busy = (byte_idx!=0) || (state==CAP).

Test Plan:
- Defaults; FIFO holds 0xDE then 0xAD, word_ready=1 -> one fifo_re pulse per byte; word_data=0xADDE valid for 1 cycle; word_cnt=1.
- BIG_ENDIAN=1, WORD_BYTES=4; bytes 0x11,0x22,0x33,0x44 -> word_data=0x11223344; byte_idx steps 1,2,3,0.
- OUT_DEPTH=2, word_ready=0, six bytes queued -> exactly 4 fifo_re pulses, then stall with fifo_empty=0. Raise word_ready -> 0x2211, 0x4433, 0x6655 out in order.
- TIMEOUT_CYC=16; push byte 0x5A, then nothing for 20 cycles -> err_timeout pulses once 16 idle cycles after the capture; byte_idx=0. Next bytes 0x01,0x02 -> 0x0201.
- flush asserted in CAP of the 2nd byte, with one word already buffered -> word_valid=0, byte_idx=0. Following bytes 0xBE,0xEF -> 0xEFBE.
- rst_n dropped mid-word with 2 words buffered -> all outputs 0 immediately (async); word_cnt=0; normal operation after release.
